// File: rtl/alu_serial_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_serial_pkg : shared ctrl and FSM state encodings for alu_serial |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alu_serial_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SLT = 4'b0111;
  localparam alu_ctrl_t ALU_NOR = 4'b1100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // Only add and sub report overflow and carry-out.
  function automatic logic alu_is_arith(input alu_ctrl_t c);
    return (c == ALU_ADD) || (c == ALU_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_bit_slice : combinational 1-bit ALU slice (AND/OR/sum/Less)     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_bit_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_ainvert,
  input  logic       i_binvert,
  input  logic       i_carry_in,
  input  logic       i_less,
  input  logic [1:0] i_operation,
  output logic       o_result,
  output logic       o_carry_out,
  output logic       o_sum
);

  logic w_ain;
  logic w_bin;

  assign w_ain       = i_ainvert ? ~i_a : i_a;
  assign w_bin       = i_binvert ? ~i_b : i_b;
  assign o_sum       = w_ain ^ w_bin ^ i_carry_in;
  assign o_carry_out = (w_ain & w_bin) | (w_ain & i_carry_in) | (w_bin & i_carry_in);

  always_comb begin
    o_result = 1'b0;
    case (i_operation)
      2'b00:   o_result = w_ain & w_bin;
      2'b01:   o_result = w_ain | w_bin;
      2'b10:   o_result = o_sum;
      default: o_result = i_less;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_serial : bit-serial WIDTH-bit ALU, LSB first, one slice/clock   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  alu_ctrl_t          r_ctrl;
  logic               r_cout_msb;
  logic               r_ovf;
  logic               r_set;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_overflow;
  logic               r_carry_out;

  logic               w_bit;
  logic               w_cout;
  logic               w_sum;
  logic [WIDTH-1:0]   w_fin_res;
  logic               w_valid;

  alu_bit_slice u_slice (
    .i_a         (r_a[0]),
    .i_b         (r_b[0]),
    .i_ainvert   (r_ctrl[3]),
    .i_binvert   (r_ctrl[2]),
    .i_carry_in  (r_carry),
    .i_less      (1'b0),
    .i_operation (r_ctrl[1:0]),
    .o_result    (w_bit),
    .o_carry_out (w_cout),
    .o_sum       (w_sum)
  );

  // slt needs the overflow-corrected sign; unsupported codes yield all zeros.
  always_comb begin
    w_fin_res = '0;
    w_valid   = 1'b1;
    case (r_ctrl)
      ALU_AND, ALU_OR, ALU_NOR, ALU_ADD, ALU_SUB: w_fin_res = r_res;
      ALU_SLT: w_fin_res = {{(WIDTH-1){1'b0}}, r_set ^ r_ovf};
      default: w_valid   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_ctrl      <= ALU_AND;
      r_cout_msb  <= 1'b0;
      r_ovf       <= 1'b0;
      r_set       <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_carry_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_ctrl  <= ctrl;
            r_carry <= ctrl[2];
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_res   <= {w_bit, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
          if (r_cnt == c_LAST) begin
            r_cout_msb <= w_cout;
            r_ovf      <= w_cout ^ r_carry;
            r_set      <= w_sum;
            r_state    <= ST_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIN: begin
          r_result    <= w_fin_res;
          r_zero      <= w_valid && (w_fin_res == '0);
          r_overflow  <= alu_is_arith(r_ctrl) & r_ovf;
          r_carry_out <= alu_is_arith(r_ctrl) & r_cout_msb;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry_out = r_carry_out;

endmodule
`default_nettype wire
